fetch_stage: RTL

Instruction fetch stage sitting directly downstream of the program counter and upstream of decode. Each cycle it turns the current word-addressed PC into an instruction-memory request. It tracks outstanding requests and buffers returned instructions with their PC in a small in-order FIFO for decode. It back-pressures the PC through `pc_stall` and discards all in-flight work on a control-flow redirect (`flush`).

---
 rtl/fetch_stage.sv | 103 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: issues PC-ordered imem requests, pairs responses with their PC, buffers them for decode.
module fetch_stage #(
    parameter int PCLEN = 10,
    parameter int ILEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PCLEN-1:0] pc,
    output logic             pc_stall,
    input  logic             flush,
    output logic             imem_req,
    output logic [PCLEN-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [ILEN-1:0]  imem_rdata,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [ILEN-1:0]  id_instr,
    output logic [PCLEN-1:0] id_pc,
    output logic [PCLEN-1:0] id_pcplus1
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic {RUN, DRAIN} state_t;
    state_t state;
    logic [CW-1:0] outstanding, count, drop, drop_next;
    logic [CW:0] occupancy;
    logic [IW-1:0] tag_wp, tag_rp, out_wp, out_rp;
    logic [PCLEN-1:0] tag_mem [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];
    logic [PCLEN-1:0] pc_mem [DEPTH];
    logic [PCLEN-1:0] pc1_mem [DEPTH];
    logic credit, grant, take, discard, pop;
    function automatic logic [IW-1:0] bump(input logic [IW-1:0] p);
        return p == IW'(DEPTH - 1) ? '0 : p + IW'(1);
    endfunction
    always_comb begin
        occupancy = {1'b0, outstanding} + {1'b0, count};
        credit = occupancy < (CW+1)'(DEPTH);
        imem_req = !reset && state == RUN && !flush && credit;
        imem_addr = pc;
        grant = imem_req && imem_gnt;
        pc_stall = !flush && !grant;
        discard = imem_rvalid && drop != '0;
        take = imem_rvalid && drop == '0 && outstanding != '0;
        id_valid = !reset && count != '0;
        pop = id_valid && id_ready;
        // on a flush, every request still in flight (dropped or not) must be swallowed later
        drop_next = flush ? drop + outstanding - CW'(discard || take) : drop - CW'(discard);
        id_instr = instr_mem[out_rp];
        id_pc = pc_mem[out_rp];
        id_pcplus1 = pc1_mem[out_rp];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            outstanding <= '0;
            count <= '0;
            drop <= '0;
            tag_wp <= '0;
            tag_rp <= '0;
            out_wp <= '0;
            out_rp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem[i] <= '0;
                instr_mem[i] <= '0;
                pc_mem[i] <= '0;
                pc1_mem[i] <= '0;
            end
        end else begin
            drop <= drop_next;
            state <= drop_next != '0 ? DRAIN : RUN;
            if (flush) begin
                outstanding <= '0;
                count <= '0;
                tag_wp <= '0;
                tag_rp <= '0;
                out_wp <= '0;
                out_rp <= '0;
            end else begin
                outstanding <= outstanding + CW'(grant) - CW'(take);
                count <= count + CW'(take) - CW'(pop);
                if (grant) begin
                    tag_mem[tag_wp] <= pc;
                    tag_wp <= bump(tag_wp);
                end
                if (take) begin
                    instr_mem[out_wp] <= imem_rdata;
                    pc_mem[out_wp] <= tag_mem[tag_rp];
                    pc1_mem[out_wp] <= tag_mem[tag_rp] + PCLEN'(1);
                    out_wp <= bump(out_wp);
                    tag_rp <= bump(tag_rp);
                end
                if (pop) out_rp <= bump(out_rp);
            end
        end
    end
    a_spurious_rsp: assert property (@(posedge clock) disable iff (reset)
        !(imem_rvalid && outstanding == '0 && drop == '0));
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        occupancy <= (CW+1)'(DEPTH));
endmodule
